// File: rtl/direct_map_cache_ctrl.sv
// Read-only direct-mapped cache with an integrated word-serial refill controller.
// Optional macro CACHE_STATS_EN adds saturating lookup/hit counters (stat_access, stat_hit).
module direct_map_cache_ctrl #(
  parameter int ADDR_W   = 15,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 2,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              flush,
  output logic              cpu_busy,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic [1:0]        dbg_state
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_access,
  output logic [31:0]       stat_hit
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;

  state_t state_q, state_d;
  // LOOKUP spans two cycles: phase 0 reads the arrays, phase 1 compares.
  logic ph_q, ph_d;

  logic [ADDR_W-1:0]   addr_q;
  logic [OFFSET_W-1:0] cnt_q;
  logic [LINES-1:0]    valid_q;
  logic                rd_valid_q;
  logic [TAG_W-1:0]    rd_tag_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   fill_word_q;

  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [DATA_W-1:0]   data_mem [LINES*WORDS];

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_off;

  logic accept, do_flush, lookup_rd, hit, miss, word_we, last_word;

  assign req_tag   = addr_q[ADDR_W-1 -: TAG_W];
  assign req_index = addr_q[OFFSET_W +: INDEX_W];
  assign req_off   = addr_q[OFFSET_W-1:0];
  assign lookup_rd = (state_q == LOOKUP) && !ph_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    accept    = 1'b0;
    do_flush  = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    word_we   = 1'b0;
    last_word = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          do_flush = 1'b1;
        end else if (cpu_req) begin
          accept  = 1'b1;
          ph_d    = 1'b0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (rd_valid_q && (rd_tag_q == req_tag)) begin
            hit     = 1'b1;
            state_d = IDLE;
          end else begin
            miss    = 1'b1;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        if (mem_valid) begin
          word_we = 1'b1;
          if (cnt_q == '1) begin
            last_word = 1'b1;
            state_d   = RESPOND;
          end
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ph_q        <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      valid_q     <= '0;
      rd_valid_q  <= 1'b0;
      fill_word_q <= '0;
      cpu_busy    <= 1'b0;
      cpu_ready   <= 1'b0;
      cpu_hit     <= 1'b0;
      cpu_rdata   <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      cpu_busy  <= (state_d != IDLE);
      mem_req   <= (state_d == REFILL);
      cpu_ready <= hit || (state_q == RESPOND);
      cpu_hit   <= hit;
      if (accept) addr_q <= cpu_addr;
      if (lookup_rd) rd_valid_q <= valid_q[req_index];
      if (miss) mem_addr <= {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      if (word_we) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == req_off) fill_word_q <= mem_data;
      end
      // Valid is only raised with the last word so a partial line never hits.
      if (last_word) valid_q[req_index] <= 1'b1;
      if (do_flush) valid_q <= '0;
      if (hit) begin
        cpu_rdata <= rd_data_q;
      end else if (state_q == RESPOND) begin
        cpu_rdata <= fill_word_q;
      end
    end
  end

  // Array storage carries no reset; valid_q alone decides whether a line exists.
  always_ff @(posedge clk) begin
    if (word_we) data_mem[{req_index, cnt_q}] <= mem_data;
    if (last_word) tag_mem[req_index] <= req_tag;
    if (lookup_rd) begin
      rd_tag_q  <= tag_mem[req_index];
      rd_data_q <= data_mem[{req_index, req_off}];
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_access <= '0;
      stat_hit    <= '0;
    end else if ((state_q == LOOKUP) && ph_q) begin
      if (stat_access != 32'hFFFF_FFFF) stat_access <= stat_access + 32'd1;
      if (hit && (stat_hit != 32'hFFFF_FFFF)) stat_hit <= stat_hit + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_direct_map_cache_ctrl.sv
// Bench for direct_map_cache_ctrl: table of reads against a memory image and a
// cache model, scoreboard of expected responses, plus flush/reset/busy sequences.
module tb_direct_map_cache_ctrl;
  localparam int ADDR_W = 15, INDEX_W = 10, OFFSET_W = 2, DATA_W = 32, WORDS = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              flush;
  logic              cpu_busy, cpu_ready, cpu_hit, mem_req, mem_valid;
  logic [DATA_W-1:0] cpu_rdata, mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        dbg_state;
`ifdef CACHE_STATS_EN
  logic [31:0]       stat_access, stat_hit;
`endif

  direct_map_cache_ctrl #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .flush(flush),
    .cpu_busy(cpu_busy), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .dbg_state(dbg_state)
`ifdef CACHE_STATS_EN
    , .stat_access(stat_access), .stat_hit(stat_hit)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W:0] exp_q[$];
  logic       model_valid [1024];
  logic [2:0] model_tag   [1024];
  int exp_access = 0;
  int exp_hit    = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic [DATA_W-1:0] data;
    int                gap_after;
  } vec_t;
  vec_t vecs [9];

  function automatic logic [31:0] mem_fn(input logic [ADDR_W-1:0] a);
    if (a[14:2] == 13'h0001) return 32'hA0 + 32'(a[1:0]);
    if (a[14:2] == 13'h0401) return 32'hB0 + 32'(a[1:0]);
    return 32'hD000_0000 + 32'(a) * 32'd3;
  endfunction

  function automatic logic model_hit(input logic [ADDR_W-1:0] a);
    return model_valid[a[11:2]] && (model_tag[a[11:2]] == a[14:12]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) model_valid[i] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one read, with the memory side answered inline; expected result goes to the scoreboard
  task automatic do_read(input logic [ADDR_W-1:0] a, input logic exp_hit_v, input logic [DATA_W-1:0] exp_data,
                         input int gap_after, input bit rnd_gaps, input bit poke, input logic [ADDR_W-1:0] poke_addr);
    int c, w, k;
    bit gap_pend, done, saw_mem;
    logic [DATA_W:0] e;
    exp_q.push_back({exp_hit_v, exp_data});
    exp_access++;
    if (exp_hit_v) exp_hit++;
    cpu_addr = a;
    cpu_req  = 1'b1;
    c = 0; w = 0; k = -1; gap_pend = 0; done = 0; saw_mem = 0;
    while (!done && c < 200) begin
      @(posedge clk); #1;
      c++;
      cpu_req   = 1'b0;
      mem_valid = 1'b0;
      mem_data  = $urandom;
      if (c == 1) chk("busy_after_accept", 64'(cpu_busy), 64'd1);
      if (k >= 0 && c == k) chk("mem_req_fall", 64'(mem_req), 64'd0);
      if (cpu_ready) begin
        done = 1;
        if (exp_q.size() == 0) begin
          chk("ready_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", 64'(cpu_rdata), 64'(e[DATA_W-1:0]));
          chk("hit", 64'(cpu_hit), 64'(e[DATA_W]));
        end
        chk("latency", 64'(c), exp_hit_v ? 64'd3 : 64'(k + 1));
        chk("mem_used", 64'(saw_mem), 64'(!exp_hit_v));
        chk("busy_at_ready", 64'(cpu_busy), 64'd0);
      end else if (mem_req && w < WORDS) begin
        if (!saw_mem) begin
          chk("mem_req_rise", 64'(c), 64'd3);
          saw_mem = 1;
          if (poke) begin
            cpu_req  = 1'b1;
            cpu_addr = poke_addr;
          end
        end
        chk("mem_addr", 64'(mem_addr), 64'({a[14:2], 2'b00}));
        if (gap_pend || (rnd_gaps && $urandom_range(0, 3) == 0)) begin
          gap_pend = 0;
        end else begin
          mem_valid = 1'b1;
          mem_data  = mem_fn({a[14:2], 2'(w)});
          if (w == gap_after) gap_pend = 1;
          w++;
          if (w == WORDS) k = c + 1;
        end
      end
    end
    if (!done) chk("read_timeout", 64'd0, 64'd1);
    if (!exp_hit_v) begin
      model_valid[a[11:2]] = 1'b1;
      model_tag[a[11:2]]   = a[14:12];
    end
  endtask

  task automatic quiet(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk(name, 64'({cpu_ready, mem_req, cpu_busy}), 64'd0);
    end
  endtask

  task automatic read_model(input logic [ADDR_W-1:0] a, input bit rnd_gaps);
    do_read(a, model_hit(a), mem_fn(a), -1, rnd_gaps, 1'b0, '0);
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0; mem_valid = 1'b0; mem_data = '0;
    model_clear();
    #12;
    chk("reset_ctrl", 64'({cpu_busy, cpu_ready, cpu_hit, mem_req}), 64'd0);
    chk("reset_rdata", 64'(cpu_rdata), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // table: cold miss then hit, conflict eviction, and a few neighbours
    vecs[0] = '{15'h0005, 1'b0, 32'hA1, 1};
    vecs[1] = '{15'h0006, 1'b1, 32'hA2, -1};
    vecs[2] = '{15'h0004, 1'b1, 32'hA0, -1};
    vecs[3] = '{15'h1004, 1'b0, 32'hB0, -1};
    vecs[4] = '{15'h0004, 1'b0, 32'hA0, -1};
    vecs[5] = '{15'h0007, 1'b1, 32'hA3, -1};
    vecs[6] = '{15'h1005, 1'b0, 32'hB1, 0};
    vecs[7] = '{15'h0003, 1'b0, mem_fn(15'h0003), 2};
    vecs[8] = '{15'h0000, 1'b1, mem_fn(15'h0000), -1};
    for (int i = 0; i < 9; i++) begin
      do_read(vecs[i].addr, vecs[i].hit, vecs[i].data, vecs[i].gap_after, 1'b0, 1'b0, '0);
`ifdef CACHE_STATS_EN
      if (i == 1) begin
        chk("stat_access_cold", 64'(stat_access), 64'd2);
        chk("stat_hit_cold", 64'(stat_hit), 64'd1);
      end
`endif
    end

    // flush beats a simultaneous request
    read_model(15'h0004, 1'b0);
    cpu_req = 1'b1; flush = 1'b1; cpu_addr = 15'h0004;
    @(posedge clk); #1;
    cpu_req = 1'b0; flush = 1'b0;
    chk("flush_no_lookup", 64'({cpu_busy, mem_req}), 64'd0);
    model_clear();
    quiet(3, "flush_quiet");
`ifdef CACHE_STATS_EN
    chk("stat_access_flush", 64'(stat_access), 64'(exp_access));
    chk("stat_hit_flush", 64'(stat_hit), 64'(exp_hit));
`endif
    do_read(15'h0004, 1'b0, 32'hA0, -1, 1'b0, 1'b0, '0);

    // reset in the middle of a refill
    cpu_addr = 15'h0008; cpu_req = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_mem_req_up", 64'(mem_req), 64'd1);
    mem_valid = 1'b1; mem_data = mem_fn(15'h0008);
    @(posedge clk); #1;
    mem_data = mem_fn(15'h0009);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    chk("rst_mid_before", 64'(mem_req), 64'd1);
    #2 rst = 1'b1;
    #1 chk("rst_mid_async_drop", 64'(mem_req), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    model_clear();
    exp_access = 0;
    exp_hit    = 0;
    quiet(4, "rst_mid_no_ready");
    do_read(15'h0008, 1'b0, mem_fn(15'h0008), -1, 1'b0, 1'b0, '0);

    // requests during refill and mem_valid while idle are ignored
    do_read(15'h0021, model_hit(15'h0021), mem_fn(15'h0021), -1, 1'b0, 1'b1, 15'h0030);
    quiet(2, "busy_poke_ignored");
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      chk("idle_mem_valid", 64'({cpu_ready, mem_req, cpu_busy}), 64'd0);
    end
    mem_valid = 1'b0;
    read_model(15'h0020, 1'b0);
    read_model(15'h0030, 1'b0);

    // random traffic over a few aliasing lines with random refill gaps
    for (int i = 0; i < 24; i++) begin
      a = {3'($urandom_range(0, 3)), 10'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      read_model(a, 1'b1);
    end
`ifdef CACHE_STATS_EN
    chk("stat_access_end", 64'(stat_access), 64'(exp_access));
    chk("stat_hit_end", 64'(stat_hit), 64'(exp_hit));
`endif
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
